// File: rtl/libv_deque_pkg.sv
// Shared command encodings and decode helpers for libv_deque.
package libv_deque_pkg;

    typedef enum logic [1:0] {
        PushFront = 2'd0,
        PopFront  = 2'd1,
        PushBack  = 2'd2,
        PopBack   = 2'd3
    } cmd_t;

    function automatic logic is_push(cmd_t c);
        return (c == PushFront) || (c == PushBack);
    endfunction

    function automatic logic is_front(cmd_t c);
        return (c == PushFront) || (c == PopFront);
    endfunction

endpackage

// File: rtl/libv_deque_ptr.sv
// Modulo-N up/down pointer; N need not be a power of two.
// Latency: ptr updates on the clock after inc/dec; ptr_m1 is combinational.
// Backpressure: none; the caller only pulses inc/dec for accepted commands.
module libv_deque_ptr #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] ptr_m1
);
    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptrP1;

    always_comb begin
        ptr_m1 = (ptr == '0)   ? LAST : ptr - PW'(1);
        ptrP1  = (ptr == LAST) ? '0   : ptr + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc && !dec)
            ptr <= ptrP1;
        else if (dec && !inc)
            ptr <= ptr_m1;
    end

endmodule

// File: rtl/libv_deque.sv
// Double-ended queue, W-bit x N circular store. Optional peek ports: LIBV_DEQUE_PEEK_EN.
// Latency: pop data registered, out_vld one cycle after accept; flags update next cycle.
// Backpressure: in_accept drops for pushes when full and pops when empty; no out-side stall.
module libv_deque
    import libv_deque_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [1:0]             in_cmd,
    input  logic [W-1:0]           in_dat,
    output logic                   in_accept,
    output logic                   out_vld,
    output logic [W-1:0]           out_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(N+1)-1:0] cnt
`ifdef LIBV_DEQUE_PEEK_EN
    ,
    output logic                   peek_vld,
    output logic [W-1:0]           peek_front_dat,
    output logic [W-1:0]           peek_back_dat
`endif
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_NEAR_FULL = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);

    logic [W-1:0]  mem [N];
    logic [PW-1:0] frontPtr, frontM1, backPtr, backM1;
    logic [PW-1:0] wrIdx, rdIdx;
    cmd_t          cmd;
    logic          isPush, isFront, doPush, doPop;

    always_comb begin
        cmd       = cmd_t'(in_cmd);
        isPush    = is_push(cmd);
        isFront   = is_front(cmd);
        in_accept = in_vld && !rst && (isPush ? !full : !empty);
        doPush    = in_accept && isPush;
        doPop     = in_accept && !isPush;
        // Front pushes land one below front_ptr; back pops read one below back_ptr.
        wrIdx     = isFront ? frontM1  : backPtr;
        rdIdx     = isFront ? frontPtr : backM1;
    end

    libv_deque_ptr #(.N(N)) uFrontPtr (
        .clk    (clk),
        .rst    (rst),
        .inc    (doPop && isFront),
        .dec    (doPush && isFront),
        .ptr    (frontPtr),
        .ptr_m1 (frontM1)
    );

    libv_deque_ptr #(.N(N)) uBackPtr (
        .clk    (clk),
        .rst    (rst),
        .inc    (doPush && !isFront),
        .dec    (doPop && !isFront),
        .ptr    (backPtr),
        .ptr_m1 (backM1)
    );

    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrIdx] <= in_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            out_vld <= doPop;
            if (doPop)
                out_dat <= mem[rdIdx];
            if (doPush) begin
                cnt   <= cnt + CW'(1);
                full  <= (cnt == CNT_NEAR_FULL);
                empty <= 1'b0;
            end else if (doPop) begin
                cnt   <= cnt - CW'(1);
                full  <= 1'b0;
                empty <= (cnt == CNT_ONE);
            end
        end
    end

`ifdef LIBV_DEQUE_PEEK_EN
    assign peek_vld       = !empty;
    assign peek_front_dat = mem[frontPtr];
    assign peek_back_dat  = mem[backM1];
`endif

endmodule

// File: tb/tb_libv_deque.sv
// Randomised + directed scoreboard bench for libv_deque (N=4, W=8) against a queue model.
module tb_libv_deque;
    import libv_deque_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inVld = 1'b0;
    logic [1:0]   inCmd = 2'd0;
    logic [W-1:0] inDat = '0;
    logic         inAccept, outVld, full, empty;
    logic [W-1:0] outDat;
    logic [2:0]   cnt;
`ifdef LIBV_DEQUE_PEEK_EN
    logic         peekVld;
    logic [W-1:0] peekFront, peekBack;
`endif

    libv_deque #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (inVld),
        .in_cmd    (inCmd),
        .in_dat    (inDat),
        .in_accept (inAccept),
        .out_vld   (outVld),
        .out_dat   (outDat),
        .full      (full),
        .empty     (empty),
        .cnt       (cnt)
`ifdef LIBV_DEQUE_PEEK_EN
        ,
        .peek_vld       (peekVld),
        .peek_front_dat (peekFront),
        .peek_back_dat  (peekBack)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic [W-1:0] model[$];
    logic [W-1:0] expQ[$];
    logic [W-1:0] lastDat = '0;
    logic         mon = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on negedge; in_accept sampled 2 time units later.
    task automatic doCmd(input cmd_t c, input logic [W-1:0] d);
        logic isPushC, expAcc;
        @(negedge clk);
        inVld = 1'b1;
        inCmd = c;
        inDat = d;
        #2;
        isPushC = (c == PushFront) || (c == PushBack);
        expAcc  = isPushC ? (model.size() < N) : (model.size() > 0);
        chk("in_accept", {31'd0, inAccept}, {31'd0, expAcc});
        if (expAcc) begin
            case (c)
                PushFront: model.push_front(d);
                PushBack:  model.push_back(d);
                PopFront:  expQ.push_back(model.pop_front());
                default:   expQ.push_back(model.pop_back());
            endcase
        end
    endtask

    task automatic idle();
        @(negedge clk);
        inVld = 1'b0;
        inCmd = 2'($urandom_range(0, 3));
        #2;
        chk("idle_accept", {31'd0, inAccept}, 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        inVld = 1'b1;
        inCmd = PopFront;
        #2;
        chk("rst_accept", {31'd0, inAccept}, 32'd0);
        model.delete();
        expQ.delete();
        lastDat = '0;
        @(negedge clk);
        rst   = 1'b0;
        inVld = 1'b0;
    endtask

    // Monitor: one check set per cycle, half a cycle after the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon) begin
                if (expQ.size() > 0) begin
                    chk("out_vld", {31'd0, outVld}, 32'd1);
                    chk("out_dat", {24'd0, outDat}, {24'd0, expQ[0]});
                    lastDat = expQ.pop_front();
                end else begin
                    chk("out_vld_idle", {31'd0, outVld}, 32'd0);
                    chk("out_dat_hold", {24'd0, outDat}, {24'd0, lastDat});
                end
                chk("cnt", {29'd0, cnt}, 32'(model.size()));
                chk("empty", {31'd0, empty}, {31'd0, model.size() == 0});
                chk("full", {31'd0, full}, {31'd0, model.size() == N});
`ifdef LIBV_DEQUE_PEEK_EN
                chk("peek_vld", {31'd0, peekVld}, {31'd0, model.size() != 0});
                if (model.size() != 0) begin
                    chk("peek_front", {24'd0, peekFront}, {24'd0, model[0]});
                    chk("peek_back", {24'd0, peekBack}, {24'd0, model[model.size()-1]});
                end
`endif
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2 mon = 1'b1;

        // FIFO order
        doCmd(PushBack, 8'h11); doCmd(PushBack, 8'h22); doCmd(PushBack, 8'h33);
        repeat (3) doCmd(PopFront, 8'h00);
        idle();

        // LIFO at the front with front pointer wrap
        doReset();
        doCmd(PushFront, 8'hA1); doCmd(PushFront, 8'hA2);
        doCmd(PopFront, 8'h00); doCmd(PopFront, 8'h00);
        idle();

        // Full, rejected push, then pops from both ends
        doCmd(PushBack, 8'h01); doCmd(PushFront, 8'h02);
        doCmd(PushBack, 8'h03); doCmd(PushFront, 8'h04);
        doCmd(PushBack, 8'h05);
        idle();
        doCmd(PopBack, 8'h00); doCmd(PopFront, 8'h00);
        doCmd(PopBack, 8'h00); doCmd(PopFront, 8'h00);

        // Pops from empty after reset
        doReset();
        doCmd(PopFront, 8'h00); doCmd(PopBack, 8'h00);
        idle();

        // Back pointer wrap and single-entry pop
        for (int i = 0; i < 4; i++) doCmd(PushBack, 8'(8'h10 + i));
        repeat (3) doCmd(PopFront, 8'h00);
        doCmd(PushBack, 8'h14); doCmd(PushBack, 8'h15);
        doCmd(PopBack, 8'h00); doCmd(PopFront, 8'h00);
        doCmd(PopBack, 8'h00);
        idle();

        // Reset in the cycle after a pop accept
        doCmd(PushBack, 8'h77); doCmd(PushBack, 8'h78);
        doCmd(PopFront, 8'h00);
        doReset();
        doCmd(PopFront, 8'h00);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)
                doReset();
            else if (r < 12)
                idle();
            else
                doCmd(cmd_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        idle(); idle();
        chk("drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
